// File: rtl/frame_sequencer_pkg.sv
// frame_sequencer_pkg: shared camera/ray types and frame sequencer state encoding
package frame_sequencer_pkg;
  localparam int FRAME_PIX_W = 19;
  localparam int VEC_W = 16;
  typedef struct packed {
    logic signed [VEC_W-1:0] x;
    logic signed [VEC_W-1:0] y;
    logic signed [VEC_W-1:0] z;
  } vector_t;
  typedef struct packed {
    vector_t dir;
    logic [FRAME_PIX_W-1:0] idx;
  } prg_ray_t;
  typedef enum logic [1:0] {IDLE, LATCH, RUN, WAIT_VS} frame_seq_state_t;
endpackage

// File: rtl/frame_sequencer_rise_det.sv
// rise_det: registered-history rising-edge detector
module rise_det (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);
  logic d_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) d_q <= 1'b0;
    else d_q <= d_i;
  assign rise_o = d_i & ~d_q;
endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: per-frame camera latch, ray-gen start and vsync retire; FRAME_PERF_EN adds frame_cycles
module frame_sequencer import frame_sequencer_pkg::*; #(
  parameter int PIX_W  = FRAME_PIX_W,
  parameter int FCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              vsync,
  input  logic              cam_valid,
  input  vector_t           E_in,
  input  vector_t           U_in,
  input  vector_t           V_in,
  input  vector_t           W_in,
  input  logic [PIX_W-1:0]  num_rays,
  input  logic              pixel_done,
  output logic              prg_start,
  output vector_t           E,
  output vector_t           U,
  output vector_t           V,
  output vector_t           W,
  output logic              busy,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_count,
  output logic              stray_pix
`ifdef FRAME_PERF_EN
  ,
  output logic [31:0]       frame_cycles
`endif
);
  localparam logic [PIX_W-1:0]  PONE = 1;
  localparam logic [FCNT_W-1:0] FONE = 1;
  frame_seq_state_t  state_q;
  vector_t           e_q, u_q, v_q, w_q;
  logic [PIX_W-1:0]  cnt_q, tgt_q, cnt_nx;
  logic [FCNT_W-1:0] fcnt_q;
  logic              prg_q, busy_q, done_q, stray_q, vs_rise;
  rise_det u_vs (.clk(clk), .rst(rst), .d_i(vsync), .rise_o(vs_rise));
  assign cnt_nx = cnt_q + PONE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      {e_q, u_q, v_q, w_q} <= '0;
      cnt_q   <= '0;
      tgt_q   <= '0;
      fcnt_q  <= '0;
      prg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      stray_q <= 1'b0;
    end else begin
      prg_q  <= 1'b0;
      done_q <= 1'b0;
      if (pixel_done && state_q != RUN) stray_q <= 1'b1;
      case (state_q)
        IDLE: if (go) begin
          state_q <= LATCH;
          busy_q  <= 1'b1;
        end
        LATCH: begin
          if (cam_valid) {e_q, u_q, v_q, w_q} <= {E_in, U_in, V_in, W_in};
          tgt_q   <= num_rays;
          cnt_q   <= '0;
          prg_q   <= num_rays != '0;
          state_q <= num_rays != '0 ? RUN : WAIT_VS;
        end
        RUN: if (pixel_done) begin
          cnt_q <= cnt_nx;
          if (cnt_nx == tgt_q) state_q <= WAIT_VS;
        end
        WAIT_VS: if (vs_rise) begin
          done_q  <= 1'b1;
          fcnt_q  <= fcnt_q + FONE;
          state_q <= go ? LATCH : IDLE;
          busy_q  <= go;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign prg_start   = prg_q;
  assign {E, U, V, W} = {e_q, u_q, v_q, w_q};
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign frame_count = fcnt_q;
  assign stray_pix   = stray_q;
`ifdef FRAME_PERF_EN
  logic [31:0] cyc_q, fc_q;
  // cyc_q holds cycles elapsed since LATCH; the window closes one cycle after the edge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cyc_q <= '0;
      fc_q  <= '0;
    end else begin
      cyc_q <= state_q == LATCH ? 32'd1 : cyc_q + 32'd1;
      if (state_q == WAIT_VS && vs_rise) fc_q <= cyc_q + 32'd2;
    end
  assign frame_cycles = fc_q;
`endif
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: table-driven check of frame_sequencer plus reset and perf sequences
module tb_frame_sequencer;
  import frame_sequencer_pkg::*;
  logic clk = 1'b0, rst = 1'b1, go = 1'b0, vsync = 1'b0, cam_valid = 1'b0, pixel_done = 1'b0;
  vector_t E_in = '0, U_in = '0, V_in = '0, W_in = '0;
  logic [18:0] num_rays = '0;
  logic prg_start, busy, frame_done, stray_pix;
  vector_t E, U, V, W;
  logic [15:0] frame_count;
`ifdef FRAME_PERF_EN
  logic [31:0] frame_cycles;
`endif
  int total = 0, bad = 0;
  localparam vector_t Z = 48'h0;
  localparam vector_t A = 48'h0001_0002_0003;
  localparam vector_t B = 48'hFFF0_7ABC_0042;
  frame_sequencer dut (
    .clk(clk), .rst(rst), .go(go), .vsync(vsync), .cam_valid(cam_valid),
    .E_in(E_in), .U_in(U_in), .V_in(V_in), .W_in(W_in), .num_rays(num_rays),
    .pixel_done(pixel_done), .prg_start(prg_start), .E(E), .U(U), .V(V), .W(W),
    .busy(busy), .frame_done(frame_done), .frame_count(frame_count), .stray_pix(stray_pix)
`ifdef FRAME_PERF_EN
    , .frame_cycles(frame_cycles)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0]  gvcp;
    vector_t     ein;
    logic [18:0] nr;
    logic [2:0]  pbd;
    logic [15:0] fc;
    logic        st;
    vector_t     e;
  } vec_t;
  vec_t tv[20];
  function automatic vec_t mk(input logic [3:0] gvcp, input vector_t ein, input logic [18:0] nr,
                              input logic [2:0] pbd, input logic [15:0] fc, input logic st, input vector_t e);
    vec_t r;
    r.gvcp = gvcp; r.ein = ein; r.nr = nr; r.pbd = pbd; r.fc = fc; r.st = st; r.e = e;
    return r;
  endfunction
  task automatic step(input logic [3:0] gvcp, input vector_t ein, input logic [18:0] nr);
    @(negedge clk);
    {go, vsync, cam_valid, pixel_done} = gvcp;
    {E_in, U_in, V_in, W_in} = {ein, ein, ein, ein};
    num_rays = nr;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [195:0] got, input logic [195:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask
  initial begin
    // gvcp = {go, vsync, cam_valid, pixel_done}; pbd = {prg_start, busy, frame_done}
    tv[0]  = mk(4'b1010, A, 19'd4, 3'b010, 16'd0, 1'b0, Z);
    tv[1]  = mk(4'b1010, A, 19'd4, 3'b110, 16'd0, 1'b0, A);
    tv[2]  = mk(4'b1011, B, 19'd4, 3'b010, 16'd0, 1'b0, A);
    tv[3]  = mk(4'b1011, B, 19'd4, 3'b010, 16'd0, 1'b0, A);
    tv[4]  = mk(4'b1011, B, 19'd4, 3'b010, 16'd0, 1'b0, A);
    tv[5]  = mk(4'b1111, B, 19'd4, 3'b010, 16'd0, 1'b0, A);
    tv[6]  = mk(4'b1110, B, 19'd4, 3'b010, 16'd0, 1'b0, A);
    tv[7]  = mk(4'b1010, B, 19'd4, 3'b010, 16'd0, 1'b0, A);
    tv[8]  = mk(4'b1110, B, 19'd4, 3'b011, 16'd1, 1'b0, A);
    tv[9]  = mk(4'b1100, B, 19'd0, 3'b010, 16'd1, 1'b0, A);
    tv[10] = mk(4'b1000, B, 19'd0, 3'b010, 16'd1, 1'b0, A);
    tv[11] = mk(4'b1100, B, 19'd0, 3'b011, 16'd2, 1'b0, A);
    tv[12] = mk(4'b1110, B, 19'd4, 3'b110, 16'd2, 1'b0, B);
    tv[13] = mk(4'b1011, A, 19'd4, 3'b010, 16'd2, 1'b0, B);
    tv[14] = mk(4'b1011, A, 19'd4, 3'b010, 16'd2, 1'b0, B);
    tv[15] = mk(4'b0011, A, 19'd4, 3'b010, 16'd2, 1'b0, B);
    tv[16] = mk(4'b0011, A, 19'd4, 3'b010, 16'd2, 1'b0, B);
    tv[17] = mk(4'b0100, A, 19'd4, 3'b001, 16'd3, 1'b0, B);
    tv[18] = mk(4'b0001, A, 19'd4, 3'b000, 16'd3, 1'b1, B);
    tv[19] = mk(4'b0000, A, 19'd4, 3'b000, 16'd3, 1'b1, B);
    repeat (3) @(negedge clk);
    chk("reset", {prg_start, busy, frame_done, frame_count, stray_pix, E, U, V, W},
        {3'b000, 16'd0, 1'b0, Z, Z, Z, Z});
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(tv[i].gvcp, tv[i].ein, tv[i].nr);
      chk($sformatf("vec%0d", i), {prg_start, busy, frame_done, frame_count, stray_pix, E, U, V, W},
          {tv[i].pbd, tv[i].fc, tv[i].st, tv[i].e, tv[i].e, tv[i].e, tv[i].e});
    end
    step(4'b1010, A, 19'd4);
    step(4'b1010, A, 19'd4);
    step(4'b1011, A, 19'd4);
    chk("run_before_rst", {prg_start, busy, frame_count, E}, {1'b0, 1'b1, 16'd3, A});
    @(negedge clk);
    {go, vsync, cam_valid, pixel_done} = 4'b0000;
    rst = 1'b1;
    #1;
    chk("rst_mid_run", {prg_start, busy, frame_done, frame_count, stray_pix, E, U, V, W},
        {3'b000, 16'd0, 1'b0, Z, Z, Z, Z});
    @(negedge clk);
    rst = 1'b0;
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
        step({1'b0, i[0], 2'b00}, Z, 19'd4);
        seen = seen | frame_done | busy | prg_start;
      end
      chk("no_done_after_rst", {seen, frame_count}, {1'b0, 16'd0});
    end
`ifdef FRAME_PERF_EN
    step(4'b1000, Z, 19'd0);
    repeat (48) step(4'b0000, Z, 19'd0);
    step(4'b0100, Z, 19'd0);
    chk("perf_window", {frame_done, busy, frame_cycles}, {1'b1, 1'b0, 32'd50});
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
